alu_stage: RTL and testbench
============================

Name: alu_stage

Overview:
- Execute (A) stage of the pipelined processor.
- Consumes the registered D->A pipeline outputs and performs ALU, address-generation and branch resolution.
- Runs an iterative multi-cycle multiplier that stalls the front end while busy.
- Registers all results toward the memory (C) stage, so this block also acts as the A->C pipeline boundary.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- ADDR_WIDTH, 32, PC/branch target width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- A_dataA  in  DATA_WIDTH  operand A.
- A_dataB  in  DATA_WIDTH  operand B / store data.
- A_PC  in  ADDR_WIDTH  PC of the instruction.
- A_BranchOffset  in  DATA_WIDTH  sign-extended branch offset.
- A_opcode  in  7  operation code.
- A_regDst  in  5  destination register.
- A_DC_rd_wr  in  2  data-cache access size/type, passed through.
- A_DC_we  in  1  data-cache write enable, passed through.
- A_MuxD  in  1  writeback source select, passed through.
- A_RF_wrd  in  1  register-file write enable.
- A_kill  in  1  instruction is a bubble.
- C_result  out  DATA_WIDTH  ALU result or memory address.
- C_storeData  out  DATA_WIDTH  copy of A_dataB.
- C_regDst  out  5  registered A_regDst.
- C_DC_rd_wr  out  2  registered A_DC_rd_wr.
- C_DC_we  out  1  registered A_DC_we, gated.
- C_MuxD  out  1  registered A_MuxD.
- C_RF_wrd  out  1  registered A_RF_wrd, gated.
- C_kill  out  1  C-stage holds a bubble.
- stall  out  1  hold D/A pipeline registers and the PC.
- branch_taken  out  1  one-cycle redirect request.
- branch_target  out  ADDR_WIDTH  redirect PC.

Behaviour:
- Opcodes:
  - 0x00 ADD (A+B); 0x01 SUB (A-B); 0x02 AND; 0x03 OR; 0x04 XOR.
  - 0x05 SLL (A << B[4:0]); 0x06 SRL (logical); 0x07 SLT (signed A<B gives 1, else 0).
  - 0x08 MUL (low DATA_WIDTH bits of A*B).
  - 0x10 LD, 0x11 ST: result = A+B (address).
  - 0x20 BEQ (taken if A==B); 0x21 BNE (taken if A!=B); 0x22 JMP (always taken).
  - Any other opcode: result 0; RF_wrd and DC_we forced 0.
- Arithmetic is modulo 2^DATA_WIDTH; carries and overflow are ignored.
- Latency: non-MUL ops take 1 cycle; C_* outputs update on the edge after the instruction is present on the A_* inputs.
- Branch:
  - target = A_PC + A_BranchOffset, truncated to ADDR_WIDTH.
  - branch_taken is registered and high for exactly one cycle.
  - Branches write C_RF_wrd=0 and C_DC_we=0.
- Kill: when A_kill=1, the instruction still flows, but C_kill=1, C_RF_wrd=0, C_DC_we=0 and branch_taken=0. A killed MUL does not start the multiplier.
- MUL FSM:
  - IDLE: a non-killed MUL arriving asserts stall combinationally in the same cycle. Next edge: load multiplicand/multiplier, count=DATA_WIDTH, go to BUSY; C_* receives a bubble (C_kill=1).
  - BUSY: one shift-add step per cycle; stall=1; C_* receives a bubble every cycle. When count reaches 1, go to DONE on the next edge.
  - DONE: stall=0. The edge leaving DONE writes the product to C_result with the latched regDst/RF_wrd and C_kill=0, then returns to IDLE.
  - Total: MUL occupies DATA_WIDTH+2 cycles; stall is high for DATA_WIDTH+1 cycles.
- While stall=1 the upstream decoupler holds A_* stable; this block ignores A_* changes during BUSY. Control fields are latched at issue.
- Reset (rst_n low, at any time including mid-MUL):
  - FSM returns to IDLE immediately; multiplier state is cleared.
  - All C_* outputs = 0, except C_kill = 1.
  - stall = 0, branch_taken = 0, branch_target = 0.
- Back-to-back MULs: the second MUL is seen in the cycle after DONE and starts a fresh sequence. No overlap.

Optional Feature:
- Macro: ALU_STAGE_FAST_MUL_EN.
- Defined: MUL is computed combinationally in one cycle like the other ops; the FSM and stall logic are removed and stall is tied to 0.
- Undefined: iterative multiplier as described above.

Test Plan:
- Reset: hold rst_n=0 -> C_kill=1, C_RF_wrd=0, stall=0, branch_taken=0. Release and drive ADD 5+7 -> next cycle C_result=12, C_RF_wrd=1.
- Arithmetic: SUB 3-5 -> 0xFFFFFFFE; SLT 0xFFFFFFFF vs 1 -> 1; SRL 0x80000000 by 31 -> 1; ST with A=0x100, B=0x20 -> C_result=0x120, C_storeData=0x20, C_DC_we=1.
- Branch: BEQ A=B=9, PC=0x40, offset=0x10 -> branch_taken=1 for one cycle, branch_target=0x50, C_RF_wrd=0. Same inputs with BNE -> branch_taken=0.
- MUL: 0x1234 * 0x10 -> stall high for 33 cycles, C_kill=1 meanwhile, then C_result=0x12340 for one cycle. 0xFFFFFFFF * 0xFFFFFFFF -> C_result=1.
- Kill: MUL or BEQ-taken with A_kill=1 -> stall=0, branch_taken=0, C_kill=1, C_RF_wrd=0.
- Reset mid-MUL: assert rst_n=0 at BUSY cycle 10 -> stall drops immediately. After release, ADD 1+1 -> C_result=2 with no stale product.

Source files
------------

// File: rtl/alu_stage.sv
// alu_stage: execute stage and A->C pipeline register.
// ALU ops, load/store address generation, branch resolution, and an
// iterative shift-add multiplier that stalls the front end while it runs.
// Optional macro ALU_STAGE_FAST_MUL_EN: single-cycle combinational MUL;
// the multiplier FSM is removed and stall is tied low.
//
// state | meaning
// IDLE  | normal single-cycle flow; a live MUL raises stall and starts
// BUSY  | one shift-add step per cycle, C stage receives bubbles
// DONE  | product ready; written to C on the edge leaving this state
module alu_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] A_dataA,
  input  logic [DATA_WIDTH-1:0] A_dataB,
  input  logic [ADDR_WIDTH-1:0] A_PC,
  input  logic [DATA_WIDTH-1:0] A_BranchOffset,
  input  logic [6:0]            A_opcode,
  input  logic [4:0]            A_regDst,
  input  logic [1:0]            A_DC_rd_wr,
  input  logic                  A_DC_we,
  input  logic                  A_MuxD,
  input  logic                  A_RF_wrd,
  input  logic                  A_kill,
  output logic [DATA_WIDTH-1:0] C_result,
  output logic [DATA_WIDTH-1:0] C_storeData,
  output logic [4:0]            C_regDst,
  output logic [1:0]            C_DC_rd_wr,
  output logic                  C_DC_we,
  output logic                  C_MuxD,
  output logic                  C_RF_wrd,
  output logic                  C_kill,
  output logic                  stall,
  output logic                  branch_taken,
  output logic [ADDR_WIDTH-1:0] branch_target
);

  localparam logic [6:0] OP_ADD = 7'h00;
  localparam logic [6:0] OP_SUB = 7'h01;
  localparam logic [6:0] OP_AND = 7'h02;
  localparam logic [6:0] OP_OR  = 7'h03;
  localparam logic [6:0] OP_XOR = 7'h04;
  localparam logic [6:0] OP_SLL = 7'h05;
  localparam logic [6:0] OP_SRL = 7'h06;
  localparam logic [6:0] OP_SLT = 7'h07;
  localparam logic [6:0] OP_MUL = 7'h08;
  localparam logic [6:0] OP_LD  = 7'h10;
  localparam logic [6:0] OP_ST  = 7'h11;
  localparam logic [6:0] OP_BEQ = 7'h20;
  localparam logic [6:0] OP_BNE = 7'h21;
  localparam logic [6:0] OP_JMP = 7'h22;

  logic [DATA_WIDTH-1:0] alu_res;
  logic                  op_valid;
  logic                  is_branch;
  logic                  br_cond;

  // Single-cycle result and branch decode from the current A inputs.
  always_comb begin
    alu_res   = '0;
    op_valid  = 1'b1;
    is_branch = 1'b0;
    br_cond   = 1'b0;
    case (A_opcode)
      OP_ADD:        alu_res = A_dataA + A_dataB;
      OP_SUB:        alu_res = A_dataA - A_dataB;
      OP_AND:        alu_res = A_dataA & A_dataB;
      OP_OR:         alu_res = A_dataA | A_dataB;
      OP_XOR:        alu_res = A_dataA ^ A_dataB;
      OP_SLL:        alu_res = A_dataA << A_dataB[4:0];
      OP_SRL:        alu_res = A_dataA >> A_dataB[4:0];
      OP_SLT:        alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(A_dataA) < $signed(A_dataB))};
`ifdef ALU_STAGE_FAST_MUL_EN
      OP_MUL:        alu_res = A_dataA * A_dataB;
`else
      OP_MUL:        alu_res = '0;
`endif
      OP_LD, OP_ST:  alu_res = A_dataA + A_dataB;
      OP_BEQ: begin
        is_branch = 1'b1;
        br_cond   = (A_dataA == A_dataB);
      end
      OP_BNE: begin
        is_branch = 1'b1;
        br_cond   = (A_dataA != A_dataB);
      end
      OP_JMP: begin
        is_branch = 1'b1;
        br_cond   = 1'b1;
      end
      default:       op_valid = 1'b0;
    endcase
  end

`ifndef ALU_STAGE_FAST_MUL_EN
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t                state, state_nxt;
  logic                  mul_issue;
  logic                  stall_raw;
  logic [DATA_WIDTH-1:0] mcand, mplier, acc;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] m_store;
  logic [4:0]            m_regDst;
  logic [1:0]            m_rd_wr;
  logic                  m_dc_we, m_muxd, m_rf_wrd;

  assign mul_issue = (A_opcode == OP_MUL) && !A_kill;

  // Multiplier state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and raw stall request.
  always_comb begin
    state_nxt = state;
    stall_raw = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mul_issue) begin
          stall_raw = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall_raw = 1'b1;
        if (count == CNT_W'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reset must drop stall at once, even if a MUL sits on the A inputs.
  assign stall = stall_raw & rst_n;

  // Shift-add datapath; control fields are captured at issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
      m_store  <= '0;
      m_regDst <= '0;
      m_rd_wr  <= '0;
      m_dc_we  <= 1'b0;
      m_muxd   <= 1'b0;
      m_rf_wrd <= 1'b0;
    end else if (state == ST_IDLE && mul_issue) begin
      mcand    <= A_dataA;
      mplier   <= A_dataB;
      acc      <= '0;
      count    <= CNT_W'(DATA_WIDTH);
      m_store  <= A_dataB;
      m_regDst <= A_regDst;
      m_rd_wr  <= A_DC_rd_wr;
      m_dc_we  <= A_DC_we;
      m_muxd   <= A_MuxD;
      m_rf_wrd <= A_RF_wrd;
    end else if (state == ST_BUSY) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CNT_W'(1);
    end
  end
`else
  assign stall = 1'b0;
`endif

  // A->C pipeline register: product, bubble, or single-cycle result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      C_result      <= '0;
      C_storeData   <= '0;
      C_regDst      <= '0;
      C_DC_rd_wr    <= '0;
      C_DC_we       <= 1'b0;
      C_MuxD        <= 1'b0;
      C_RF_wrd      <= 1'b0;
      C_kill        <= 1'b1;
      branch_taken  <= 1'b0;
      branch_target <= '0;
    end else
`ifndef ALU_STAGE_FAST_MUL_EN
    if (state == ST_DONE) begin
      C_result     <= acc;
      C_storeData  <= m_store;
      C_regDst     <= m_regDst;
      C_DC_rd_wr   <= m_rd_wr;
      C_DC_we      <= m_dc_we;
      C_MuxD       <= m_muxd;
      C_RF_wrd     <= m_rf_wrd;
      C_kill       <= 1'b0;
      branch_taken <= 1'b0;
    end else if (state == ST_BUSY || mul_issue) begin
      C_result     <= '0;
      C_storeData  <= '0;
      C_regDst     <= '0;
      C_DC_rd_wr   <= '0;
      C_DC_we      <= 1'b0;
      C_MuxD       <= 1'b0;
      C_RF_wrd     <= 1'b0;
      C_kill       <= 1'b1;
      branch_taken <= 1'b0;
    end else
`endif
    begin
      C_result      <= alu_res;
      C_storeData   <= A_dataB;
      C_regDst      <= A_regDst;
      C_DC_rd_wr    <= A_DC_rd_wr;
      C_DC_we       <= A_DC_we & op_valid & ~is_branch & ~A_kill;
      C_MuxD        <= A_MuxD;
      C_RF_wrd      <= A_RF_wrd & op_valid & ~is_branch & ~A_kill;
      C_kill        <= A_kill;
      branch_taken  <= is_branch & br_cond & ~A_kill;
      branch_target <= A_PC + ADDR_WIDTH'(A_BranchOffset);
    end
  end

endmodule

// File: tb/tb_alu_stage.sv
// Scoreboard bench for alu_stage: the driver pushes the expected C-stage
// record for every live instruction, the monitor pops one whenever C_kill
// is low. Expected values come from plain arithmetic on the operands.
module tb_alu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] A_dataA, A_dataB, A_PC, A_BranchOffset;
  logic [6:0]  A_opcode;
  logic [4:0]  A_regDst;
  logic [1:0]  A_DC_rd_wr;
  logic        A_DC_we, A_MuxD, A_RF_wrd, A_kill;
  logic [31:0] C_result, C_storeData;
  logic [4:0]  C_regDst;
  logic [1:0]  C_DC_rd_wr;
  logic        C_DC_we, C_MuxD, C_RF_wrd, C_kill, stall, branch_taken;
  logic [31:0] branch_target;

  alu_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .A_dataA(A_dataA), .A_dataB(A_dataB), .A_PC(A_PC),
    .A_BranchOffset(A_BranchOffset), .A_opcode(A_opcode),
    .A_regDst(A_regDst), .A_DC_rd_wr(A_DC_rd_wr), .A_DC_we(A_DC_we),
    .A_MuxD(A_MuxD), .A_RF_wrd(A_RF_wrd), .A_kill(A_kill),
    .C_result(C_result), .C_storeData(C_storeData), .C_regDst(C_regDst),
    .C_DC_rd_wr(C_DC_rd_wr), .C_DC_we(C_DC_we), .C_MuxD(C_MuxD),
    .C_RF_wrd(C_RF_wrd), .C_kill(C_kill), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target)
  );

  always #5 clk = ~clk;

`ifdef ALU_STAGE_FAST_MUL_EN
  localparam int MUL_STALL = 0;
`else
  localparam int MUL_STALL = 33;
`endif

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [1:0]  rw;
    logic        we, mux, wrd, bt, is_br;
    logic [31:0] btgt;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: what the C stage must show for one live instruction.
  function automatic exp_t model(input logic [6:0] op, input logic [31:0] a, b, pc, off,
                                 input logic [4:0] rd, input logic [1:0] rw,
                                 input logic we, mux, wrd);
    exp_t e;
    logic [4:0] sh;
    sh = b[4:0];
    e.res = 32'h0; e.sd = b; e.rd = rd; e.rw = rw; e.we = we; e.mux = mux;
    e.wrd = wrd; e.bt = 1'b0; e.is_br = 1'b0; e.btgt = pc + off;
    case (op)
      7'h00, 7'h10, 7'h11: e.res = a + b;
      7'h01: e.res = a - b;
      7'h02: e.res = a & b;
      7'h03: e.res = a | b;
      7'h04: e.res = a ^ b;
      7'h05: e.res = a << sh;
      7'h06: e.res = a >> sh;
      7'h07: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      7'h08: e.res = a * b;
      7'h20, 7'h21, 7'h22: begin
        e.is_br = 1'b1;
        e.bt  = (op == 7'h22) || (op == 7'h20 && a == b) || (op == 7'h21 && a != b);
        e.wrd = 1'b0;
        e.we  = 1'b0;
      end
      default: begin e.wrd = 1'b0; e.we = 1'b0; end
    endcase
    return e;
  endfunction

  // Monitor: every non-bubble C-stage output consumes one expected record.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n === 1'b1 && C_kill === 1'b0) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: C_result %h appeared, expected no live output", C_result);
      end else begin
        e = q.pop_front();
        if (!e.is_br) check("C_result", C_result, e.res);
        check("C_storeData", C_storeData, e.sd);
        check("C_regDst", {27'b0, C_regDst}, {27'b0, e.rd});
        check("C_DC_rd_wr", {30'b0, C_DC_rd_wr}, {30'b0, e.rw});
        check("C_DC_we", {31'b0, C_DC_we}, {31'b0, e.we});
        check("C_MuxD", {31'b0, C_MuxD}, {31'b0, e.mux});
        check("C_RF_wrd", {31'b0, C_RF_wrd}, {31'b0, e.wrd});
        check("branch_taken", {31'b0, branch_taken}, {31'b0, e.bt});
        if (e.bt) check("branch_target", branch_target, e.btgt);
      end
    end
  end

  task automatic issue(input logic [6:0] op, input logic [31:0] a, b, pc, off,
                       input logic kill, wrd, we);
    logic [4:0] rd;
    logic [1:0] rw;
    logic       mux;
    int         n;
    rd  = 5'($urandom);
    rw  = 2'($urandom);
    mux = 1'($urandom);
    @(negedge clk);
    A_opcode = op; A_dataA = a; A_dataB = b; A_PC = pc; A_BranchOffset = off;
    A_regDst = rd; A_DC_rd_wr = rw; A_MuxD = mux; A_RF_wrd = wrd; A_DC_we = we;
    A_kill = kill;
    if (!kill) q.push_back(model(op, a, b, pc, off, rd, rw, we, mux, wrd));
    #1;
    if (op == 7'h08 && !kill) begin
      n = 0;
      while (stall === 1'b1 && n < 100) begin
        n++;
        @(negedge clk);
        #1;
      end
      check("mul_stall_cycles", n, MUL_STALL);
    end else begin
      check("stall_low", {31'b0, stall}, 32'h0);
      if (kill) begin
        @(posedge clk);
        #2;
        check("kill_C_kill", {31'b0, C_kill}, 32'h1);
        check("kill_C_RF_wrd", {31'b0, C_RF_wrd}, 32'h0);
        check("kill_C_DC_we", {31'b0, C_DC_we}, 32'h0);
        check("kill_branch_taken", {31'b0, branch_taken}, 32'h0);
      end
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  logic [6:0] ops [15] = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07,
                           7'h08, 7'h10, 7'h11, 7'h20, 7'h21, 7'h22, 7'h3F};

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    A_opcode = 7'h08; A_dataA = 32'h3; A_dataB = 32'h4; A_PC = 32'h0;
    A_BranchOffset = 32'h0; A_regDst = 5'd1; A_DC_rd_wr = 2'd0; A_DC_we = 1'b0;
    A_MuxD = 1'b0; A_RF_wrd = 1'b1; A_kill = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_C_kill", {31'b0, C_kill}, 32'h1);
    check("rst_C_RF_wrd", {31'b0, C_RF_wrd}, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_branch_taken", {31'b0, branch_taken}, 32'h0);
    check("rst_branch_target", branch_target, 32'h0);
    check("rst_C_result", C_result, 32'h0);
    A_opcode = 7'h3F; A_kill = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    issue(7'h00, 32'd5, 32'd7, 0, 0, 0, 1, 0);
    issue(7'h01, 32'd3, 32'd5, 0, 0, 0, 1, 0);
    issue(7'h07, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 1, 0);
    issue(7'h06, 32'h8000_0000, 32'd31, 0, 0, 0, 1, 0);
    issue(7'h11, 32'h100, 32'h20, 0, 0, 0, 0, 1);
    issue(7'h20, 32'd9, 32'd9, 32'h40, 32'h10, 0, 1, 1);
    issue(7'h21, 32'd9, 32'd9, 32'h40, 32'h10, 0, 1, 1);
    issue(7'h08, 32'h1234, 32'h10, 0, 0, 0, 1, 0);
    issue(7'h00, 32'd2, 32'd2, 0, 0, 0, 1, 0);
    issue(7'h08, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 1, 0);
    issue(7'h08, 32'd6, 32'd7, 0, 0, 0, 1, 0);
    issue(7'h08, 32'd6, 32'd7, 0, 0, 1, 1, 0);
    issue(7'h20, 32'd9, 32'd9, 32'h40, 32'h10, 1, 1, 0);
    issue(7'h3F, 32'd1, 32'd2, 0, 0, 0, 1, 1);

    // Reset in the middle of a multiply.
    @(negedge clk);
    A_opcode = 7'h08; A_dataA = 32'h77; A_dataB = 32'h55; A_kill = 1'b0; A_RF_wrd = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("midmul_stall_high", {31'b0, stall}, 32'(MUL_STALL != 0));
    rst_n = 1'b0;
    #1;
    check("midmul_rst_stall", {31'b0, stall}, 32'h0);
    check("midmul_rst_C_kill", {31'b0, C_kill}, 32'h1);
    A_opcode = 7'h3F; A_kill = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    issue(7'h00, 32'd1, 32'd1, 0, 0, 0, 1, 0);

    for (int i = 0; i < 300; i++) begin
      ra = rand_operand();
      rb = ($urandom_range(0, 3) == 0) ? ra : rand_operand();
      issue(ops[$urandom_range(0, 14)], ra, rb, $urandom, $urandom,
            ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    A_kill = 1'b1; A_opcode = 7'h3F;
    repeat (4) @(negedge clk);
    check("queue_drained", q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
